// File: rtl/fft_bfly_tw_if.sv
// Butterfly port bundle: upstream operands, twiddle ROM link, downstream
// results and the saturation status pair. The master drives operands, the
// ROM data and out_ready; the slave is the butterfly itself.
interface fft_bfly_tw_if #(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a_re;
   logic [DATA_W-1:0] in_a_im;
   logic [DATA_W-1:0] in_b_re;
   logic [DATA_W-1:0] in_b_im;
   logic [3:0]        in_tw_idx;
   logic [3:0]        tw_addr;
   logic [15:0]       tw;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_x0_re;
   logic [DATA_W-1:0] out_x0_im;
   logic [DATA_W-1:0] out_x1_re;
   logic [DATA_W-1:0] out_x1_im;
   logic              sat_flag;
   logic              sat_clr;

   modport master (
      output in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_tw_idx,
      output tw, out_ready, sat_clr,
      input  in_ready, tw_addr, out_valid,
      input  out_x0_re, out_x0_im, out_x1_re, out_x1_im, sat_flag
   );

   modport slave (
      input  in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_tw_idx,
      input  tw, out_ready, sat_clr,
      output in_ready, tw_addr, out_valid,
      output out_x0_re, out_x0_im, out_x1_re, out_x1_im, sat_flag
   );
endinterface

// File: rtl/fft_bfly_tw.sv
// Three-stage radix-2 DIT butterfly with twiddle ROM lookup.
// S1 captures operands and issues the ROM address, S2 forms P = W*B in Q1.7
// (twiddle arrives combinationally from the ROM), S3 forms (A +/- P)/2 with
// saturation. A single enable stalls the whole pipe under backpressure.
module fft_bfly_tw #(
   parameter int DATA_W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   fft_bfly_tw_if.slave   bus
);
   localparam int PRODW = DATA_W + 8;   // 16x8 product
   localparam int SUMW  = DATA_W + 9;   // sum of two products
   localparam int PW    = DATA_W + 2;   // P after >>> 7
   localparam int SW    = DATA_W + 3;   // A +/- P
   localparam int HW    = DATA_W + 2;   // (A +/- P) >>> 1 before clipping
   localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

   logic w_en;

   // Index 0 = real, 1 = imaginary
   logic                     r_s1_valid;
   logic signed [DATA_W-1:0] r_s1_a [2];
   logic signed [DATA_W-1:0] r_s1_b [2];
   logic [3:0]               r_tw_addr;

   logic                     r_s2_valid;
   logic signed [DATA_W-1:0] r_s2_a [2];
   logic signed [PW-1:0]     r_s2_p [2];

   logic                     r_out_valid;
   logic [DATA_W-1:0]        r_out [4];   // x0_re, x0_im, x1_re, x1_im
   logic                     r_sat_flag;

   logic signed [7:0]        w_c;
   logic signed [7:0]        w_s;
   logic signed [PRODW-1:0]  w_br_c, w_bi_s, w_bi_c, w_br_s;
   logic signed [SUMW-1:0]   w_sum_re, w_sum_im;
   logic [3:0]               w_clip;
   logic [DATA_W-1:0]        w_x_sat [4];

   // The pipe advances whenever the output slot is empty or being drained
   assign w_en = ~r_out_valid | bus.out_ready;

   assign bus.in_ready  = w_en;
   assign bus.tw_addr   = r_tw_addr;
   assign bus.out_valid = r_out_valid;
   assign bus.out_x0_re = r_out[0];
   assign bus.out_x0_im = r_out[1];
   assign bus.out_x1_re = r_out[2];
   assign bus.out_x1_im = r_out[3];
   assign bus.sat_flag  = r_sat_flag;

   // S1: capture operands and present the twiddle index to the ROM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_tw_addr  <= '0;
         for (int i = 0; i < 2; i++) begin
            r_s1_a[i] <= '0;
            r_s1_b[i] <= '0;
         end
      end else if (w_en) begin
         r_s1_valid <= bus.in_valid;
         r_tw_addr  <= bus.in_tw_idx;
         r_s1_a[0]  <= bus.in_a_re;
         r_s1_a[1]  <= bus.in_a_im;
         r_s1_b[0]  <= bus.in_b_re;
         r_s1_b[1]  <= bus.in_b_im;
      end
   end

   // ROM answers for the address registered in S1, so it pairs with S1's B
   assign w_c = bus.tw[15:8];
   assign w_s = bus.tw[7:0];

   assign w_br_c   = PRODW'(r_s1_b[0]) * PRODW'(w_c);
   assign w_bi_s   = PRODW'(r_s1_b[1]) * PRODW'(w_s);
   assign w_bi_c   = PRODW'(r_s1_b[1]) * PRODW'(w_c);
   assign w_br_s   = PRODW'(r_s1_b[0]) * PRODW'(w_s);
   assign w_sum_re = SUMW'(w_br_c) + SUMW'(w_bi_s);
   assign w_sum_im = SUMW'(w_bi_c) - SUMW'(w_br_s);

   // S2: register P = W*B (Q1.7 scaling removed, floor) and delay A
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            r_s2_a[i] <= '0;
            r_s2_p[i] <= '0;
         end
      end else if (w_en) begin
         r_s2_valid <= r_s1_valid;
         r_s2_a[0]  <= r_s1_a[0];
         r_s2_a[1]  <= r_s1_a[1];
         r_s2_p[0]  <= PW'(w_sum_re >>> 7);
         r_s2_p[1]  <= PW'(w_sum_im >>> 7);
      end
   end

   // Per output component: halve (A +/- P) with floor, then clip to DATA_W
   for (genvar gi = 0; gi < 4; gi++) begin : g_comp
      localparam int CI = gi % 2;
      logic signed [SW-1:0] w_full;
      logic signed [HW-1:0] w_half;
      logic [2:0]           w_top;

      if (gi < 2) begin : g_add
         assign w_full = SW'(r_s2_a[CI]) + SW'(r_s2_p[CI]);
      end else begin : g_sub
         assign w_full = SW'(r_s2_a[CI]) - SW'(r_s2_p[CI]);
      end

      assign w_half      = HW'(w_full >>> 1);
      assign w_top       = w_half[HW-1:DATA_W-1];
      assign w_clip[gi]  = ~((&w_top) | ~(|w_top));
      assign w_x_sat[gi] = w_clip[gi] ? (w_top[2] ? MIN_VAL : MAX_VAL)
                                      : w_half[DATA_W-1:0];
   end

   // S3: register the saturated results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         for (int i = 0; i < 4; i++) r_out[i] <= '0;
      end else if (w_en) begin
         r_out_valid <= r_s2_valid;
         for (int i = 0; i < 4; i++) r_out[i] <= w_x_sat[i];
      end
   end

   // Sticky clip indicator; a new clip in the same cycle beats a clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_sat_flag <= 1'b0;
      else if (w_en && r_s2_valid && (|w_clip))
         r_sat_flag <= 1'b1;
      else if (bus.sat_clr)
         r_sat_flag <= 1'b0;
   end
endmodule

// File: tb/tb_fft_bfly_tw.sv
// Bench for fft_bfly_tw: directed spec vectors, reset, backpressure, bubbles
// and randomized traffic checked against an integer-arithmetic model.
module tb_fft_bfly_tw;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_bfly_tw_if #(.DATA_W(16)) bus ();

   fft_bfly_tw #(.DATA_W(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Twiddle ROM: W = exp(-j*2*pi*k/32), stored as cos and +sin in Q1.7
   int cos_tab [16] = '{127, 125, 117, 106, 90, 71, 49, 25,
                        0, -25, -49, -71, -90, -106, -117, -125};
   int sin_tab [16] = '{0, 25, 49, 71, 90, 106, 117, 125,
                        127, 125, 117, 106, 90, 71, 49, 25};
   logic [7:0] rom_c, rom_s;
   always_comb begin
      rom_c = cos_tab[bus.tw_addr][7:0];
      rom_s = sin_tab[bus.tw_addr][7:0];
   end
   assign bus.tw = {rom_c, rom_s};

   typedef struct {
      int x0r; int x0i; int x1r; int x1i; bit clip;
   } res_t;

   res_t exp_q [$];
   bit   exp_sat;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_out    = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      n_checks++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
   endtask

   function automatic int sat16(input int v, inout bit clip);
      if (v > 32767) begin clip = 1'b1; return 32767; end
      if (v < -32768) begin clip = 1'b1; return -32768; end
      return v;
   endfunction

   function automatic res_t model(input int ar, input int ai, input int br,
                                  input int bi, input int k);
      res_t r;
      bit   cl;
      int   c, s, pr, pi;
      c  = cos_tab[k];
      s  = sin_tab[k];
      pr = (br * c + bi * s) >>> 7;
      pi = (bi * c - br * s) >>> 7;
      cl = 1'b0;
      r.x0r  = sat16((ar + pr) >>> 1, cl);
      r.x0i  = sat16((ai + pi) >>> 1, cl);
      r.x1r  = sat16((ar - pr) >>> 1, cl);
      r.x1i  = sat16((ai - pi) >>> 1, cl);
      r.clip = cl;
      return r;
   endfunction

   // Scoreboard: every cycle, check handshakes and outputs against the model
   always @(negedge clk) begin
      res_t e;
      if (rst_n) begin
         chk("in_ready", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("x0_re", $signed(bus.out_x0_re), e.x0r);
               chk("x0_im", $signed(bus.out_x0_im), e.x0i);
               chk("x1_re", $signed(bus.out_x1_re), e.x1r);
               chk("x1_im", $signed(bus.out_x1_im), e.x1i);
               n_out++;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            e = model($signed(bus.in_a_re), $signed(bus.in_a_im),
                      $signed(bus.in_b_re), $signed(bus.in_b_im), int'(bus.in_tw_idx));
            exp_q.push_back(e);
            exp_sat |= e.clip;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input int ar, input int ai, input int br, input int bi,
                        input int k, input bit v);
      bus.in_valid  = v;
      bus.in_a_re   = 16'(ar);
      bus.in_a_im   = 16'(ai);
      bus.in_b_re   = 16'(br);
      bus.in_b_im   = 16'(bi);
      bus.in_tw_idx = 4'(k);
   endtask

   // Present one butterfly; it is accepted at the following rising edge
   task automatic send(input int ar, input int ai, input int br, input int bi, input int k);
      int t;
      @(posedge clk) #1 drive(ar, ai, br, bi, k, 1'b1);
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("send_timeout", 0, 1);
   endtask

   task automatic idle();
      @(posedge clk) #1 bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) chk("drain_timeout", 0, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic sat_clear();
      @(posedge clk) #1 bus.sat_clr = 1'b1;
      @(posedge clk) #1 bus.sat_clr = 1'b0;
      exp_sat = 1'b0;
   endtask

   // Single butterfly on an idle pipe; reports outputs and latency in cycles
   task automatic run_one(input int ar, input int ai, input int br, input int bi,
                          input int k, output int o0r, output int o0i,
                          output int o1r, output int o1i, output int lat);
      @(posedge clk) #1 drive(ar, ai, br, bi, k, 1'b1);
      @(posedge clk) #1 bus.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      o0r = $signed(bus.out_x0_re);
      o0i = $signed(bus.out_x0_im);
      o1r = $signed(bus.out_x1_re);
      o1i = $signed(bus.out_x1_im);
   endtask

   task automatic rand_phase(input int n, input int amp);
      int nacc, cyc;
      nacc = 0;
      cyc  = 0;
      while (nacc < n && cyc < 20000) begin
         @(posedge clk) #1;
         drive(int'($urandom_range(0, 2 * amp - 1)) - amp,
               int'($urandom_range(0, 2 * amp - 1)) - amp,
               int'($urandom_range(0, 2 * amp - 1)) - amp,
               int'($urandom_range(0, 2 * amp - 1)) - amp,
               int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) nacc++;
         cyc++;
      end
      if (cyc >= 20000) chk("rand_timeout", 0, 1);
      @(posedge clk) #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drain();
   endtask

   initial begin
      int o0r, o0i, o1r, o1i, lat, n0;
      int snap0, snap1, snap_tw;
      bit hist [32];
      res_t m;

      drive(0, 0, 0, 0, 0, 1'b0);
      bus.out_ready = 1'b1;
      bus.sat_clr   = 1'b0;
      exp_sat       = 1'b0;

      // Model anchors computed by hand
      m = model(1000, 0, 1000, 0, 8);
      chk("model_k8_x0i", m.x0i, -497);
      m = model(-32768, -32768, -32768, -32768, 4);
      chk("model_k4_x1r", m.x1r, 6656);

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_tw_addr", int'(bus.tw_addr), 0);
      chk("rst_sat_flag", int'(bus.sat_flag), 0);
      chk("rst_x0_re", int'(bus.out_x0_re), 0);
      rst_n = 1'b1;

      // k = 0: W = 1
      run_one(1000, 0, 1000, 0, 0, o0r, o0i, o1r, o1i, lat);
      chk("k0_latency", lat, 3);
      chk("k0_x0_re", o0r, 996);
      chk("k0_x0_im", o0i, 0);
      chk("k0_x1_re", o1r, 4);
      chk("k0_x1_im", o1i, 0);
      chk("k0_sat", int'(bus.sat_flag), 0);
      drain();

      // k = 8: W = -j
      run_one(1000, 0, 1000, 0, 8, o0r, o0i, o1r, o1i, lat);
      chk("k8_latency", lat, 3);
      chk("k8_x0_re", o0r, 500);
      chk("k8_x0_im", o0i, -497);
      chk("k8_x1_re", o1r, 500);
      chk("k8_x1_im", o1i, 496);
      chk("k8_sat", int'(bus.sat_flag), 0);
      drain();

      // k = 4: most-negative operands, x0_re clips
      run_one(-32768, -32768, -32768, -32768, 4, o0r, o0i, o1r, o1i, lat);
      chk("k4_x0_re", o0r, -32768);
      chk("k4_x0_im", o0i, -16384);
      chk("k4_x1_re", o1r, 6656);
      chk("k4_x1_im", o1i, -16384);
      chk("k4_sat_set", int'(bus.sat_flag), 1);
      drain();
      sat_clear();
      @(negedge clk);
      chk("sat_clr", int'(bus.sat_flag), 0);

      // Reset with butterflies in flight
      send(-32768, -32768, -32768, -32768, 4);
      send(100, 200, 300, 400, 5);
      send(-100, 50, 20, -70, 5);
      send(7, 8, 9, 10, 5);
      idle();
      chk("pre_rst_sat", int'(bus.sat_flag), 1);
      chk("pre_rst_tw_addr", int'(bus.tw_addr), 5);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", int'(bus.out_valid), 0);
      chk("rst_mid_sat", int'(bus.sat_flag), 0);
      chk("rst_mid_tw_addr", int'(bus.tw_addr), 0);
      exp_q.delete();
      exp_sat = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("post_rst_stale", int'(bus.out_valid), 0);
      end

      // Backpressure: 6 back-to-back, 4-cycle stall while out_valid=1
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(i * 1000 - 2500, 300 - i * 77, 1234 + i * 500, -4321 + i, 3 + i);
            idle();
         end
         begin
            int t;
            t = 0;
            @(negedge clk);
            while (!bus.out_valid && t < 50) begin
               @(negedge clk);
               t++;
            end
            if (t >= 50) chk("bp_wait_timeout", 0, 1);
            @(posedge clk) #1 bus.out_ready = 1'b0;
            @(negedge clk);
            snap0   = int'(bus.out_x0_re);
            snap1   = int'(bus.out_x1_im);
            snap_tw = int'(bus.tw_addr);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("bp_in_ready", int'(bus.in_ready), 0);
               chk("bp_out_valid", int'(bus.out_valid), 1);
               chk("bp_hold_x0_re", int'(bus.out_x0_re), snap0);
               chk("bp_hold_x1_im", int'(bus.out_x1_im), snap1);
               chk("bp_hold_tw_addr", int'(bus.tw_addr), snap_tw);
            end
            @(posedge clk) #1 bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_count", n_out - n0, 6);
      chk("bp_queue_empty", exp_q.size(), 0);

      // Bubbles: out_valid must follow in_valid three cycles later
      for (int i = 0; i < 22; i++) begin
         @(posedge clk) #1;
         drive(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
               int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
               int'($urandom_range(0, 15)), (i < 14) && (i % 2 == 0));
         @(negedge clk);
         hist[i] = bus.in_valid;
         chk("bubble_valid", int'(bus.out_valid), (i >= 3) ? int'(hist[i-3]) : 0);
      end
      drain();

      // Random traffic without clipping, then full-scale with clipping
      sat_clear();
      rand_phase(150, 8192);
      chk("rand_small_sat", int'(bus.sat_flag), int'(exp_sat));
      sat_clear();
      rand_phase(150, 32768);
      chk("rand_full_sat", int'(bus.sat_flag), int'(exp_sat));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fft_bfly_tw.md
Name: fft_bfly_tw

Overview:
- Pipelined radix-2 DIT butterfly for the 32-point FFT datapath.
- It is the consumer side of the twiddle ROM interface: it drives a registered 4-bit twiddle address out to the ROM and takes back the 16-bit packed twiddle combinationally in the same cycle.
- It computes A + W·B and A − W·B, scaled by 1/2, with saturation.
- Sits between the stage address sequencer (upstream, valid/ready) and the ping-pong sample memory (downstream, valid/ready).

Parameters:
- DATA_W, 16, width of each real/imag sample component, signed two's complement.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  butterfly operands valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a_re, in_a_im  in  DATA_W each  operand A.
- in_b_re, in_b_im  in  DATA_W each  operand B.
- in_tw_idx  in  4  twiddle index k, where W = exp(−j2πk/32).
- tw_addr  out  4  registered twiddle address to ROM.
- tw  in  16  packed twiddle from ROM: [15:8] = cos, [7:0] = sin, each signed Q1.7.
- out_valid  out  1  results valid.
- out_ready  in  1  downstream accepts results.
- out_x0_re, out_x0_im  out  DATA_W each  (A + W·B)/2.
- out_x1_re, out_x1_im  out  DATA_W each  (A − W·B)/2.
- sat_flag  out  1  sticky: any output component saturated.
- sat_clr  in  1  synchronous clear of sat_flag.

Behaviour:
- Reset (async, rst_n=0): all pipeline valids = 0, out_valid = 0, tw_addr = 0, all out_* data = 0, sat_flag = 0. Reset mid-operation discards all in-flight butterflies; nothing is emitted after release until new inputs are accepted.
- Pipeline enable: en = ~out_valid | out_ready. in_ready = en, driven combinationally. All three stages advance together only when en=1. When en=0, every stage register, including tw_addr, holds its value.
- S1 (capture): on en, register A, B, and valid = in_valid & in_ready. tw_addr <= in_tw_idx on en, whether or not in_valid is set.
- S2 (multiply): on en, latch c = tw[15:8] and s = tw[7:0] against the S1 contents. Compute:
  - p_re = (b_re·c + b_im·s) >>> 7
  - p_im = (b_im·c − b_re·s) >>> 7
  - Products are 16×8 signed giving 24 bits; each sum is 25 bits.
  - Arithmetic shift with floor truncation, kept at DATA_W+2 bits.
  - Delay A alongside.
- S3 (add/scale): on en, compute:
  - x0 = (A + P) >>> 1 and x1 = (A − P) >>> 1 per component, at DATA_W+3 bits, floor.
  - Saturate each component to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Register into out_*. out_valid <= S2 valid.
- Latency: exactly 3 clk from input acceptance to out_valid, with out_ready held 1. Throughput is 1 butterfly/clk.
- Output data is held stable while out_valid=1 and out_ready=0.
- Bubbles (in_valid=0 while en=1) propagate as valid=0. Output data registers may update during bubbles but are don't-care while out_valid=0.
- sat_flag is set on any S3 register update with valid=1 in which any of the 4 components clipped. sat_clr=1 clears it. If clear and set occur in the same cycle, set wins.
- The ROM is purely combinational, so tw must be sampled only in S2, one cycle after tw_addr is updated.

Test Plan:
- Reset: rst_n=0 mid-stream with 3 butterflies in flight -> out_valid=0, sat_flag=0, tw_addr=0 immediately; after release, no stale outputs appear.
- k=0 (tw=0x7f00): A=(1000,0), B=(1000,0) -> after 3 clk, x0=(996,0), x1=(4,0), sat_flag=0.
- k=8 (tw=0x007f): A=(1000,0), B=(1000,0) -> P=(0,−993), x0=(500,−497), x1=(500,496).
- k=4 (tw=0x5a5a): A=B=(−32768,−32768) -> P=(−46080,0), x0=(−32768 saturated, −16384), x1=(6656,−16384), sat_flag=1. Then sat_clr=1 for one cycle -> sat_flag=0.
- Backpressure: stream 6 butterflies back-to-back, drop out_ready for 4 clk while out_valid=1:
  - in_ready=0 and outputs/tw_addr frozen during the stall.
  - All 6 results emerge in order, none lost or duplicated.
- Bubbles: alternate in_valid 1/0 with out_ready=1 -> out_valid pattern equals in_valid pattern delayed 3 clk.
